// File: rtl/serial_bit_adder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, with a carry
// flip-flop chaining bits so words of any length can be summed.
module serial_bit_adder (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic carry_q;
  logic first_q;
  logic ci;
  logic sum_d;
  logic carry_d;

  // The external carry-in only seeds bit 0; later bits chain the stored carry.
  always_comb begin
    ci      = first_q ? cin : carry_q;
    sum_d   = a ^ b ^ ci;
    carry_d = (a & b) | (a & ci) | (b & ci);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
      first_q <= 1'b1;
      s       <= 1'b0;
      cout    <= 1'b0;
    end else begin
      carry_q <= carry_d;
      first_q <= 1'b0;
      s       <= sum_d;
      cout    <= carry_d;
    end
  end

endmodule

// File: tb/tb_serial_bit_adder.sv
// Self-checking bench for serial_bit_adder: directed cases plus random words,
// checked against a word-level arithmetic reference (A + B + cin).
module tb_serial_bit_adder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic cin = 1'b0;
  logic s;
  logic cout;

  int compared = 0;
  int mismatched = 0;

  // Reference: operands accumulated as integers; sum bit k and carry out are
  // bits of the plain arithmetic total of the bits seen so far.
  logic [63:0] wa, wb, wc, full;
  int          nbits;
  logic [63:0] obs_word;

  serial_bit_adder dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle(input string tag, input logic r, input logic ra, input logic rb,
                          input logic rcin);
    logic exp_s, exp_c;
    @(negedge clk);
    reset = r;
    a     = ra;
    b     = rb;
    cin   = rcin;
    @(posedge clk);
    #1;
    if (r) begin
      wa = '0; wb = '0; wc = '0; nbits = 0; obs_word = '0;
      exp_s = 1'b0;
      exp_c = 1'b0;
    end else begin
      if (nbits == 0) wc = {63'd0, rcin};
      wa[nbits] = ra;
      wb[nbits] = rb;
      full  = wa + wb + wc;
      exp_s = full[nbits];
      exp_c = full[nbits+1];
      obs_word[nbits]   = s;
      obs_word[nbits+1] = cout;
      nbits++;
    end
    check($sformatf("%s s bit%0d", tag, nbits), s, exp_s);
    check($sformatf("%s cout bit%0d", tag, nbits), cout, exp_c);
  endtask

  task automatic add_word(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vcin, input int len);
    for (int i = 0; i < len; i++)
      do_cycle(tag, 1'b0, va[i], vb[i], (i == 0) ? vcin : 1'($urandom_range(0, 1)));
  endtask

  initial begin
    wa = '0; wb = '0; wc = '0; full = '0; nbits = 0; obs_word = '0;

    // 1: 1010 + 1110 -> 11000
    do_cycle("t1 rst", 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("t1 rst", 1'b1, 1'b0, 1'b0, 1'b0);
    add_word("t1", 32'b1010, 32'b1110, 1'b0, 4);
    check_word("t1 result", obs_word & 64'h1f, 64'b11000);

    // 2: carry-in on bit 0 propagates into bit 1
    do_cycle("t2 rst", 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("t2", 1'b0, 1'b1, 1'b0, 1'b1);
    do_cycle("t2", 1'b0, 1'b0, 1'b0, 1'b0);
    check_word("t2 result", obs_word & 64'h7, 64'b010);

    // 3: mid-word cin has no effect
    do_cycle("t3 rst", 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("t3", 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle("t3", 1'b0, 1'b0, 1'b0, 1'b1);
    check_word("t3 result", obs_word & 64'h7, 64'b000);

    // 4: 001011 + 101000 -> 0110011
    do_cycle("t4 rst", 1'b1, 1'b0, 1'b0, 1'b0);
    add_word("t4", 32'b001011, 32'b101000, 1'b0, 6);
    check_word("t4 result", obs_word & 64'h7f, 64'b0110011);

    // 5: reset mid-word discards the pending carry
    do_cycle("t5 rst", 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("t5", 1'b0, 1'b1, 1'b1, 1'b0);
    do_cycle("t5 rst", 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle("t5", 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: reset held with inputs high, then with X inputs; release adds 1+1+1
    do_cycle("t6 rst", 1'b1, 1'b1, 1'b1, 1'b1);
    do_cycle("t6 rst", 1'b1, 1'b1, 1'b1, 1'b1);
    do_cycle("t6 rst", 1'b1, 1'b1, 1'b1, 1'b1);
    do_cycle("t6 rstx", 1'b1, 1'bx, 1'bx, 1'bx);
    do_cycle("t6", 1'b0, 1'b1, 1'b1, 1'b1);

    // Random words, random lengths, occasional aborted words
    for (int w = 0; w < 40; w++) begin
      int len;
      len = int'($urandom_range(1, 32));
      for (int r = 0; r < int'($urandom_range(1, 2)); r++)
        do_cycle("rnd rst", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) len = int'($urandom_range(1, len));
      add_word($sformatf("rnd w%0d", w), $urandom, $urandom, 1'($urandom), len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
